mem_access_unit: RTL

//  Memory stage directly downstream of the execute stage. Accepts load/store

---
 rtl/mem_access_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Memory stage: turns execute-stage load/store requests into single-outstanding
// req/ack bus accesses, with byte-lane steering and load data formatting.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex2mem_mem_en_i,
  input  logic        ex2mem_we_i,
  input  logic [2:0]  ex2mem_funct3_i,
  input  logic [31:0] ex2mem_addr_i,
  input  logic [31:0] ex2mem_data_i,
  input  logic [4:0]  ex2mem_rd_i,
  output logic        mem2bus_req_o,
  output logic        mem2bus_we_o,
  output logic [31:0] mem2bus_addr_o,
  output logic [3:0]  mem2bus_be_o,
  output logic [31:0] mem2bus_wdata_o,
  input  logic        bus2mem_ack_i,
  input  logic [31:0] bus2mem_rdata_i,
  output logic        mem2cu_stall_o,
  output logic        mem2cu_misalign_o,
  output logic        mem2cu_err_o,
  output logic        mem2regs_wb_en_o,
  output logic [4:0]  mem2regs_rd_addr_o,
  output logic [31:0] mem2regs_rd_data_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WB = 2'd2} state_t;

  state_t           r_state, w_next;
  logic [31:0]      r_addr, r_data, r_rd_data;
  logic             r_we;
  logic [2:0]       r_funct3;
  logic [4:0]       r_rd, r_rd_addr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_misalign, r_err, r_wb_en;

  logic        w_open, w_legal, w_aligned, w_accept, w_misalign;
  logic        w_in_req, w_timeout, w_ld_ack;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld_data;

  assign w_open    = (r_state == S_IDLE) || (r_state == S_WB);
  assign w_in_req  = (r_state == S_REQ);
  assign w_timeout = !bus2mem_ack_i && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_ld_ack  = w_in_req && bus2mem_ack_i && !r_we;

  always_comb begin
    w_legal   = 1'b0;
    w_aligned = 1'b0;
    if (ex2mem_we_i)
      w_legal = !ex2mem_funct3_i[2] && (ex2mem_funct3_i[1:0] != 2'b11);
    else
      w_legal = (ex2mem_funct3_i[1:0] != 2'b11) && !(ex2mem_funct3_i[2] && ex2mem_funct3_i[1]);
    case (ex2mem_funct3_i[1:0])
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = !ex2mem_addr_i[0];
      2'b10:   w_aligned = (ex2mem_addr_i[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
  end

  // Misalignment is only reported for ops that would otherwise be legal.
  assign w_accept   = w_open && ex2mem_mem_en_i && w_legal && w_aligned;
  assign w_misalign = w_open && ex2mem_mem_en_i && w_legal && !w_aligned;

  always_comb begin
    w_byte = 8'h00;
    case (r_addr[1:0])
      2'b00: w_byte = bus2mem_rdata_i[7:0];
      2'b01: w_byte = bus2mem_rdata_i[15:8];
      2'b10: w_byte = bus2mem_rdata_i[23:16];
      2'b11: w_byte = bus2mem_rdata_i[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = r_addr[1] ? bus2mem_rdata_i[31:16] : bus2mem_rdata_i[15:0];
    case (r_funct3)
      3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_ld_data = {24'h000000, w_byte};
      3'b101:  w_ld_data = {16'h0000, w_half};
      default: w_ld_data = bus2mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_WB: w_next = w_accept ? S_REQ : S_IDLE;
      S_REQ: begin
        if (bus2mem_ack_i) w_next = r_we ? S_IDLE : S_WB;
        else if (w_timeout) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_data     <= '0;
      r_we       <= 1'b0;
      r_funct3   <= '0;
      r_rd       <= '0;
      r_cnt      <= '0;
      r_misalign <= 1'b0;
      r_err      <= 1'b0;
      r_wb_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_data  <= '0;
    end else begin
      if (w_accept) begin
        r_addr   <= ex2mem_addr_i;
        r_data   <= ex2mem_data_i;
        r_we     <= ex2mem_we_i;
        r_funct3 <= ex2mem_funct3_i;
        r_rd     <= ex2mem_rd_i;
        r_cnt    <= '0;
      end else if (w_in_req && !bus2mem_ack_i) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_misalign <= w_misalign;
      r_err      <= w_in_req && w_timeout;
      r_wb_en    <= w_ld_ack && (r_rd != 5'd0);
      if (w_ld_ack) begin
        r_rd_addr <= r_rd;
        r_rd_data <= w_ld_data;
      end
    end
  end

  // Bus fields are gated by REQ so they read zero outside an access.
  always_comb begin
    mem2bus_req_o   = 1'b0;
    mem2bus_we_o    = 1'b0;
    mem2bus_addr_o  = '0;
    mem2bus_be_o    = '0;
    mem2bus_wdata_o = '0;
    if (w_in_req) begin
      mem2bus_req_o  = 1'b1;
      mem2bus_we_o   = r_we;
      mem2bus_addr_o = {r_addr[31:2], 2'b00};
      case (r_funct3[1:0])
        2'b00: begin
          mem2bus_be_o    = 4'b0001 << r_addr[1:0];
          mem2bus_wdata_o = {4{r_data[7:0]}};
        end
        2'b01: begin
          mem2bus_be_o    = r_addr[1] ? 4'b1100 : 4'b0011;
          mem2bus_wdata_o = {2{r_data[15:0]}};
        end
        default: begin
          mem2bus_be_o    = 4'b1111;
          mem2bus_wdata_o = r_data;
        end
      endcase
    end
  end

  assign mem2cu_stall_o     = w_accept || (w_in_req && !bus2mem_ack_i);
  assign mem2cu_misalign_o  = r_misalign;
  assign mem2cu_err_o       = r_err;
  assign mem2regs_wb_en_o   = r_wb_en;
  assign mem2regs_rd_addr_o = r_rd_addr;
  assign mem2regs_rd_data_o = r_rd_data;

endmodule
